prog_mem_loader: RTL and testbench
==================================

// Module: prog_mem_loader
// PURPOSE
//  Boot-time controller for the program memory. Receives a little-endian byte stream,
//  assembles 32-bit words and writes them to consecutive memory words from address 0.
//  Holds the core in reset while loading. After the load it hands the memory address
//  port to the instruction-fetch path.
//  Sits between the byte receiver, the core fetch unit and the program memory.
// PARAMETERS
//  ADDR_WIDTH  10    word-address width of the program memory
//  DATA_WIDTH  32    memory word width; fixed at 32 (4 bytes per word)
//  MEM_DEPTH   1024  number of memory words
// PORTS
//  clk          in   1             clock; all state updates on rising edge
//  rst_n        in   1             asynchronous active-low reset
//  load_start   in   1             1-cycle pulse: begin a load of load_len words
//  load_len     in   ADDR_WIDTH+1  word count, 0..MEM_DEPTH; sampled on load_start
//  rx_valid     in   1             byte available
//  rx_data      in   8             byte value
//  rx_ready     out  1             byte accepted when rx_valid & rx_ready
//  fetch_req    in   1             core fetch request
//  fetch_addr   in   ADDR_WIDTH    core fetch word address
//  fetch_gnt    out  1             fetch address is driven onto mem_addr this cycle
//  mem_addr     out  ADDR_WIDTH    memory word address
//  mem_we       out  1             memory write strobe, 1 cycle per word
//  mem_wdata    out  32            memory write data
//  core_rst_n   out  1             core reset, active low
//  busy         out  1             high in LOAD and WDONE
//  done         out  1             1-cycle pulse when a load completes
//  err          out  1             sticky: load_start with load_len > MEM_DEPTH
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, core_rst_n=0, rx_ready=0, mem_we=0, mem_wdata=0,
//   mem_addr=0, fetch_gnt=0, busy=0, done=0, err=0, wptr=0, byte_cnt=0.
//   Asserting rst_n mid-load aborts the load; the memory contents are then undefined.
//  States: IDLE, LOAD, WDONE, RUN.
//  IDLE: core held in reset; rx_ready=0.
//   load_start with load_len<=MEM_DEPTH: latch len, wptr=0, byte_cnt=0, go to LOAD.
//  load_start with load_len>MEM_DEPTH: set err=1, state unchanged. Only rst_n clears err.
//  load_start with load_len=0: go directly to WDONE; no writes.
//  LOAD: rx_ready=1, core_rst_n=0, fetch_gnt=0.
//   On each rx handshake, place the byte in word[8*byte_cnt+7 : 8*byte_cnt];
//   byte_cnt increments modulo 4.
//   On the handshake with byte_cnt==3, the next cycle shows:
//   mem_we=1, mem_addr=wptr, mem_wdata=assembled word. wptr then increments.
//   mem_we stays high for exactly one cycle. rx_ready stays 1, so back-to-back bytes
//   are legal.
//   When the write of word len-1 issues, the next state is WDONE and rx_ready drops
//   in that same next cycle.
//   load_start during LOAD is ignored.
//  WDONE (1 cycle): done=1, mem_we=0. Next state is RUN.
//  RUN: core_rst_n=1. mem_addr=fetch_addr (combinational), fetch_gnt=fetch_req,
//   mem_we=0, rx_ready=0.
//   load_start in RUN: same checks as in IDLE. A valid load goes to LOAD, drives
//   core_rst_n=0 from the next cycle, and revokes fetch_gnt in that cycle.
//  Memory read data goes from the memory straight to the core with a 1-cycle
//   synchronous read latency; this block does not touch the read data.
//  mem_addr in LOAD/WDONE/IDLE is the registered write address. Upper bits are
//   truncated to ADDR_WIDTH.
// TESTING
//  1) Reset, load_len=1, bytes 78,56,34,12 back-to-back -> mem_we 1 cycle,
//     mem_addr=0, wdata=0x12345678; done next cycle; core_rst_n=1 after.
//  2) load_len=3, rx_valid toggled randomly -> three writes: addr 0,1,2 with correct
//     words; no write before 4th byte.
//  3) load_len=0 -> done 1 cycle after start, no mem_we; RUN; fetch_req=1,
//     fetch_addr=0x2A -> mem_addr=0x2A, fetch_gnt=1.
//  4) load_len=MEM_DEPTH+1 -> err=1, state unchanged; load_len=MEM_DEPTH
//     -> last write addr=0x3FF.
//  5) In RUN, load_start, len=2 -> fetch_gnt=0, core_rst_n=0 next cycle; done after 8 bytes.
//  6) rst_n low after 6 of 8 bytes -> all outputs at reset values immediately;
//     further rx_valid is ignored.

Source files
------------

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: boot loader that packs a little-endian byte stream into program memory words,
// holds the core in reset while loading, then hands the memory address port to instruction fetch.
module prog_mem_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_load_start,
   input  logic [ADDR_WIDTH:0]   i_load_len,
   input  logic                  i_rx_valid,
   input  logic [7:0]            i_rx_data,
   output logic                  o_rx_ready,
   input  logic                  i_fetch_req,
   input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
   output logic                  o_fetch_gnt,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic                  o_mem_we,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   output logic                  o_core_rst_n,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err
);
   typedef enum logic [1:0] {IDLE, LOAD, WDONE, RUN} state_t;
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);
   state_t                r_state, w_next;
   logic [ADDR_WIDTH:0]   r_len, r_wptr;
   logic [1:0]            r_cnt;
   logic [23:0]           r_word;
   logic                  r_we, r_err;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  w_idle_run, w_start_ok, w_start_bad, w_hs, w_last;
   assign w_idle_run  = r_state == IDLE || r_state == RUN;
   assign w_start_ok  = i_load_start && w_idle_run && i_load_len <= DEPTH;
   assign w_start_bad = i_load_start && w_idle_run && i_load_len > DEPTH;
   assign w_hs        = i_rx_valid && o_rx_ready;
   assign w_last      = r_state == LOAD && r_we && r_wptr == r_len;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   always_comb
      w_next = r_state == WDONE ? RUN :
               w_start_ok ? (i_load_len == '0 ? WDONE : LOAD) :
               w_last ? WDONE : r_state;
   always_comb begin
      o_rx_ready   = r_state == LOAD;
      o_busy       = r_state == LOAD || r_state == WDONE;
      o_done       = r_state == WDONE;
      o_core_rst_n = r_state == RUN;
      o_fetch_gnt  = r_state == RUN && i_fetch_req;
      o_mem_addr   = r_state == RUN ? i_fetch_addr : r_addr;
   end
   assign o_mem_we    = r_we;
   assign o_mem_wdata = r_wdata;
   assign o_err       = r_err;
   // Bytes shift in from the top so that after three bytes byte 0 sits in bits [7:0].
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_len   <= '0;
         r_wptr  <= '0;
         r_cnt   <= '0;
         r_word  <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_we <= w_hs && r_cnt == 2'd3;
         if (w_start_bad) r_err <= 1'b1;
         if (w_start_ok) begin
            r_len  <= i_load_len;
            r_wptr <= '0;
            r_cnt  <= '0;
         end else if (w_hs) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= {i_rx_data, r_word[23:8]};
            if (r_cnt == 2'd3) begin
               r_addr  <= r_wptr[ADDR_WIDTH-1:0];
               r_wdata <= {i_rx_data, r_word};
               r_wptr  <= r_wptr + 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed bench for the boot loader with a write logger and immediate assertions.
module tb_prog_mem_loader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_load_start = 1'b0;
   logic [10:0] i_load_len = '0;
   logic        i_rx_valid = 1'b0;
   logic [7:0]  i_rx_data = '0;
   logic        o_rx_ready;
   logic        i_fetch_req = 1'b0;
   logic [9:0]  i_fetch_addr = '0;
   logic        o_fetch_gnt;
   logic [9:0]  o_mem_addr;
   logic        o_mem_we;
   logic [31:0] o_mem_wdata;
   logic        o_core_rst_n, o_busy, o_done, o_err;
   int total = 0;
   int bad = 0;
   int dones = 0;
   logic [9:0]  wr_addr[$];
   logic [31:0] wr_data[$];

   prog_mem_loader dut (
      .clk(clk), .rst_n(rst_n), .i_load_start(i_load_start), .i_load_len(i_load_len),
      .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
      .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr), .o_fetch_gnt(o_fetch_gnt),
      .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
      .o_core_rst_n(o_core_rst_n), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_mem_we) begin
         wr_addr.push_back(o_mem_addr);
         wr_data.push_back(o_mem_wdata);
      end
      if (o_done) dones++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [10:0] len);
      i_load_start = 1'b1;
      i_load_len = len;
      step();
      i_load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      i_rx_valid = 1'b0;
      repeat (gap) step();
      i_rx_valid = 1'b1;
      i_rx_data = b;
      n = 0;
      while (!o_rx_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("rx_ready_timeout", 64'(o_rx_ready), 64'd1);
      step();
      i_rx_valid = 1'b0;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      dones = 0;
   endtask

   initial begin
      #3;
      chk("rst_core_rst_n", 64'(o_core_rst_n), 64'd0);
      chk("rst_rx_ready", 64'(o_rx_ready), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
      chk("rst_err", 64'(o_err), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      // 1) single word, back-to-back bytes
      start(11'd1);
      chk("t1_busy", 64'(o_busy), 64'd1);
      chk("t1_rx_ready", 64'(o_rx_ready), 64'd1);
      chk("t1_core_rst", 64'(o_core_rst_n), 64'd0);
      send_byte(8'h78, 0);
      send_byte(8'h56, 0);
      send_byte(8'h34, 0);
      chk("t1_no_early_we", 64'(o_mem_we), 64'd0);
      send_byte(8'h12, 0);
      chk("t1_we", 64'(o_mem_we), 64'd1);
      chk("t1_addr", 64'(o_mem_addr), 64'd0);
      chk("t1_wdata", 64'(o_mem_wdata), 64'h12345678);
      chk("t1_done_early", 64'(o_done), 64'd0);
      step();
      chk("t1_done", 64'(o_done), 64'd1);
      chk("t1_we_off", 64'(o_mem_we), 64'd0);
      chk("t1_rx_ready_off", 64'(o_rx_ready), 64'd0);
      step();
      chk("t1_core_run", 64'(o_core_rst_n), 64'd1);
      chk("t1_done_pulse", 64'(o_done), 64'd0);
      chk("t1_busy_off", 64'(o_busy), 64'd0);
      // 2) three words with random gaps
      clear_log();
      start(11'd3);
      for (int i = 1; i <= 12; i++) begin
         send_byte(8'(i), int'($urandom_range(0, 2)));
         if (i == 3) chk("t2_no_write_3b", 64'(wr_addr.size()), 64'd0);
      end
      step();
      step();
      chk("t2_nwrites", 64'(wr_addr.size()), 64'd3);
      if (wr_addr.size() == 3) begin
         chk("t2_a0", 64'(wr_addr[0]), 64'd0);
         chk("t2_d0", 64'(wr_data[0]), 64'h04030201);
         chk("t2_a1", 64'(wr_addr[1]), 64'd1);
         chk("t2_d1", 64'(wr_data[1]), 64'h08070605);
         chk("t2_a2", 64'(wr_addr[2]), 64'd2);
         chk("t2_d2", 64'(wr_data[2]), 64'h0C0B0A09);
      end
      chk("t2_dones", 64'(dones), 64'd1);
      chk("t2_core_run", 64'(o_core_rst_n), 64'd1);
      // 3) zero-length load, then fetch
      clear_log();
      start(11'd0);
      chk("t3_done", 64'(o_done), 64'd1);
      step();
      chk("t3_core_run", 64'(o_core_rst_n), 64'd1);
      chk("t3_no_we", 64'(wr_addr.size()), 64'd0);
      i_fetch_req = 1'b1;
      i_fetch_addr = 10'h2A;
      #1;
      chk("t3_fetch_addr", 64'(o_mem_addr), 64'h2A);
      chk("t3_fetch_gnt", 64'(o_fetch_gnt), 64'd1);
      // 4) oversize rejected, full-depth accepted
      start(11'd1025);
      chk("t4_err", 64'(o_err), 64'd1);
      chk("t4_still_run", 64'(o_core_rst_n), 64'd1);
      chk("t4_not_busy", 64'(o_busy), 64'd0);
      clear_log();
      start(11'd1024);
      for (int w = 0; w < 1024; w++) begin
         send_byte(8'(w), 0);
         send_byte(8'(w >> 8), 0);
         send_byte(8'h00, 0);
         send_byte(8'hA5, 0);
      end
      step();
      step();
      chk("t4_nwrites", 64'(wr_addr.size()), 64'd1024);
      if (wr_addr.size() == 1024) begin
         chk("t4_first_data", 64'(wr_data[0]), 64'hA5000000);
         chk("t4_last_addr", 64'(wr_addr[1023]), 64'h3FF);
         chk("t4_last_data", 64'(wr_data[1023]), 64'hA50003FF);
      end
      chk("t4_err_sticky", 64'(o_err), 64'd1);
      // 5) reload from RUN revokes fetch
      clear_log();
      start(11'd2);
      chk("t5_gnt_revoked", 64'(o_fetch_gnt), 64'd0);
      chk("t5_core_rst", 64'(o_core_rst_n), 64'd0);
      chk("t5_load_addr", 64'(o_mem_addr), 64'h3FF);
      for (int i = 0; i < 8; i++) send_byte(8'(8'hF0 + i), 0);
      step();
      chk("t5_done", 64'(o_done), 64'd1);
      chk("t5_nwrites", 64'(wr_addr.size()), 64'd2);
      if (wr_addr.size() == 2) chk("t5_d1", 64'(wr_data[1]), 64'hF7F6F5F4);
      step();
      // 6) reset mid-load
      clear_log();
      start(11'd2);
      for (int i = 0; i < 6; i++) send_byte(8'(i), 0);
      rst_n = 1'b0;
      #1;
      chk("t6_rx_ready", 64'(o_rx_ready), 64'd0);
      chk("t6_busy", 64'(o_busy), 64'd0);
      chk("t6_core_rst", 64'(o_core_rst_n), 64'd0);
      chk("t6_err", 64'(o_err), 64'd0);
      chk("t6_mem_addr", 64'(o_mem_addr), 64'd0);
      chk("t6_wdata", 64'(o_mem_wdata), 64'd0);
      chk("t6_gnt", 64'(o_fetch_gnt), 64'd0);
      chk("t6_done", 64'(o_done), 64'd0);
      step();
      rst_n = 1'b1;
      i_rx_valid = 1'b1;
      repeat (6) step();
      chk("t6_ignored_rx", 64'(o_rx_ready), 64'd0);
      chk("t6_no_writes", 64'(wr_addr.size()), 64'd1);
      i_rx_valid = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
